lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator between the core's execute stage and the word-wide data memory (1024 x 32, one-cycle registered read, full-word write only).
- Accepts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests.
- Generates memory read/write strobes with word addressing.
- Performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with a valid pulse and error flag.
- Stalls the pipeline via req_ready.

Parameters:
- ADDR_W, 32, byte address width.
- MEM_DEPTH, 1024, memory size in 32-bit words; byte addresses >= 4*MEM_DEPTH are out of range.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted when valid&ready.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RV32I width/sign code.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, 32, store data, right-aligned.
- rsp_valid, output, 1, one-cycle completion pulse.
- rsp_rdata, output, 32, extended load data; 0 for stores and errors.
- rsp_err, output, 1, misaligned, out-of-range or illegal funct3.
- mem_addr, output, ADDR_W, byte address to memory; low 2 bits always 0.
- mem_read, output, 1, memory read enable.
- mem_write_en, output, 1, memory write enable.
- mem_write_data, output, 32, memory write data.
- mem_data_out, input, 32, memory read data, valid the cycle after mem_read.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; latched request registers clear.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_read=0, mem_write_en=0, mem_addr=0, mem_write_data=0.
  - req_ready=1 once in IDLE.
- Memory-side outputs are decoded from state plus latched registers only. A reset mid-operation therefore kills any pending access in the same cycle; no write is issued after rst_n falls.
- States: IDLE, ACCESS, LOAD_DATA, RMW_MERGE, RESP_ERR.
- IDLE (req_ready=1): on req_valid, latch we/funct3/addr/wdata and check legality.
  - Illegal -> RESP_ERR.
  - Legal -> ACCESS.
  - Illegal means: funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= 4*MEM_DEPTH.
- ACCESS (req_ready=0): mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Load: mem_read=1 -> LOAD_DATA.
  - SW: mem_write_en=1, mem_write_data=wdata, rsp_valid=1 -> IDLE.
  - SB/SH: mem_read=1 -> RMW_MERGE.
- LOAD_DATA: select the byte/halfword from mem_data_out by addr[1:0], little-endian (byte 0 = bits [7:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rsp_valid=1, rsp_rdata = result -> IDLE.
- RMW_MERGE: mem_write_en=1, same mem_addr. mem_write_data = mem_data_out with the selected byte or halfword lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged. rsp_valid=1 -> IDLE.
- RESP_ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory strobes -> IDLE.
- Latency from acceptance edge: SW and error responses 1 cycle; loads 2 cycles; SB/SH 2 cycles.
- rsp_valid, rsp_rdata and rsp_err are combinational from state and are 0 outside response states.
- Next request can be accepted the cycle after rsp_valid; no back-to-back overlap.
- req_valid while req_ready=0 is ignored; the requester holds it.
- mem_read and mem_write_en are never both high in the same cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned halfword/word accesses go to RESP_ERR as above.
- Undefined: misalignment is not an error; the address is aligned down (halfword clears bit 0, word clears bits [1:0]) and the access proceeds normally. Illegal funct3 and out-of-range addresses still set rsp_err.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum lsu_state_t.
  - helper functions load_extend(word, off, funct3) and store_merge(old, wdata, off, funct3).
- Sub-module lsu_align: combinational legality check plus extend/merge datapath, instantiated once. The FSM stays in lsu_mem_master.

Test Plan:
- Word 0x4 preloaded 0xDEADBEEF. LB 0x7 -> rsp_rdata 0xFFFFFFDE; LBU 0x7 -> 0x000000DE; LH 0x6 -> 0xFFFFDEAD; LHU 0x4 -> 0x0000BEEF. Each returns rsp_valid exactly 2 cycles after acceptance.
- SB addr 0x5, wdata 0x00000012 -> one mem_read then one mem_write_en with 0xDEAD12EF; a subsequent LW 0x4 returns 0xDEAD12EF.
- SW addr 0x28, wdata 0x00000032 -> mem_write_en in the cycle after acceptance, rsp_valid same cycle; LW 0x28 -> 0x00000032.
- LW addr 0x2 with LSU_MISALIGN_TRAP_EN -> rsp_err=1, no strobes. Without the macro -> returns word 0x0.
- LW addr 0x1000, and funct3=3'b011 -> rsp_err=1 one cycle after acceptance, rsp_rdata=0.
- SH 0x8 accepted, rst_n pulled low during RMW_MERGE -> mem_write_en drops immediately, word 0x8 unchanged, req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// and the load-extend / store-merge helpers used by the lsu_align datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        LOAD_DATA,
        RMW_MERGE,
        RESP_ERR
    } lsu_state_t;

    // Little-endian lane select, then sign/zero extension by width code.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_W:    result = word;
            F3_BU:   result = {24'b0, b};
            F3_HU:   result = {16'b0, h};
            default: result = '0;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  funct3);
        logic [31:0] result;
        result = old;
        case (funct3)
            F3_B: begin
                case (off)
                    2'd0:    result[7:0]   = wdata[7:0];
                    2'd1:    result[15:8]  = wdata[7:0];
                    2'd2:    result[23:16] = wdata[7:0];
                    default: result[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) result[31:16] = wdata[15:0];
                else        result[15:0]  = wdata[15:0];
            end
            F3_W:    result = wdata;
            default: result = old;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Request legality check plus load-extend / store-merge datapath.
// LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are errors; otherwise they are aligned down.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              chk_we,
    input  logic [2:0]        chk_funct3,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_legal,
    output logic [ADDR_W-1:0] chk_addr_eff,
    input  logic [2:0]        dp_funct3,
    input  logic [1:0]        dp_off,
    input  logic [31:0]       dp_rdata,
    input  logic [31:0]       dp_wdata,
    output logic [31:0]       dp_load,
    output logic [31:0]       dp_merge
);

    // One extra bit so the limit never wraps for narrow address widths.
    localparam logic [ADDR_W:0] RANGE_LIMIT = (ADDR_W+1)'(4 * MEM_DEPTH);

    logic f3_ok;
    logic in_range;
    logic is_half;
    logic is_word;

    always_comb begin
        is_half  = (chk_funct3 == F3_H) || (chk_funct3 == F3_HU);
        is_word  = (chk_funct3 == F3_W);
        in_range = ({1'b0, chk_addr} < RANGE_LIMIT);
        if (chk_we)
            f3_ok = (chk_funct3 == F3_B) || (chk_funct3 == F3_H) || (chk_funct3 == F3_W);
        else
            f3_ok = (chk_funct3 == F3_B)  || (chk_funct3 == F3_H) || (chk_funct3 == F3_W) ||
                    (chk_funct3 == F3_BU) || (chk_funct3 == F3_HU);
        chk_addr_eff = chk_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        chk_legal = f3_ok && in_range &&
                    !((is_half && chk_addr[0]) || (is_word && (chk_addr[1:0] != 2'b00)));
`else
        chk_legal = f3_ok && in_range;
        if (is_half) chk_addr_eff[0]   = 1'b0;
        if (is_word) chk_addr_eff[1:0] = 2'b00;
`endif
    end

    always_comb begin
        dp_load  = load_extend(dp_rdata, dp_off, dp_funct3);
        dp_merge = store_merge(dp_rdata, dp_wdata, dp_off, dp_funct3);
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator FSM driving a word-wide, one-cycle-read data memory.
// Build option LSU_MISALIGN_TRAP_EN (see lsu_align) selects trap vs. align-down on misalignment.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_data_out
);

    lsu_state_t state, next_state;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              legal;
    logic [ADDR_W-1:0] addr_eff;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              is_sw;

    lsu_align #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_align (
        .chk_we       (req_we),
        .chk_funct3   (req_funct3),
        .chk_addr     (req_addr),
        .chk_legal    (legal),
        .chk_addr_eff (addr_eff),
        .dp_funct3    (funct3_q),
        .dp_off       (addr_q[1:0]),
        .dp_rdata     (mem_data_out),
        .dp_wdata     (wdata_q),
        .dp_load      (load_data),
        .dp_merge     (merge_data)
    );

    assign is_sw = we_q && (funct3_q == F3_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // The request is captured only on acceptance, so memory strobes depend on registered values alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state == IDLE && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= addr_eff;
            wdata_q  <= req_wdata;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (req_valid) next_state = legal ? ACCESS : RESP_ERR;
            ACCESS: begin
                if (!we_q)      next_state = LOAD_DATA;
                else if (is_sw) next_state = IDLE;
                else            next_state = RMW_MERGE;
            end
            LOAD_DATA: next_state = IDLE;
            RMW_MERGE: next_state = IDLE;
            RESP_ERR:  next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        mem_addr       = '0;
        mem_read       = 1'b0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            ACCESS: begin
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (is_sw) begin
                    mem_write_en   = 1'b1;
                    mem_write_data = wdata_q;
                    rsp_valid      = 1'b1;
                end else begin
                    mem_read = 1'b1;
                end
            end
            LOAD_DATA: begin
                rsp_valid = 1'b1;
                rsp_rdata = load_data;
            end
            RMW_MERGE: begin
                mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
                mem_write_en   = 1'b1;
                mem_write_data = merge_data;
                rsp_valid      = 1'b1;
            end
            RESP_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a 1024x32 registered-read memory model.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:1023];

    int          checks = 0;
    int          passed = 0;
    int          failed = 0;
    int          rsp_lat;
    int          n_reads;
    int          n_writes;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic        overlap = 1'b0;

    lsu_mem_master #(
        .ADDR_W    (32),
        .MEM_DEPTH (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_data_out   (mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: full-word write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[11:2]] <= mem_write_data;
        if (mem_read)     mem_data_out <= mem[mem_addr[11:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    // Issues one request, then watches up to 4 cycles for the response and memory strobes.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) checkOutput("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_lat   = 0;
        n_reads   = 0;
        n_writes  = 0;
        got_rdata = 'x;
        got_err   = 1'bx;
        wr_data   = '0;
        wr_addr   = '0;
        rd_addr   = '0;
        for (int c = 1; c <= 4 && rsp_lat == 0; c++) begin
            @(negedge clk);
            if (mem_read) begin
                n_reads++;
                rd_addr = mem_addr;
            end
            if (mem_write_en) begin
                n_writes++;
                wr_data = mem_write_data;
                wr_addr = mem_addr;
            end
            if (mem_read && mem_write_en) overlap = 1'b1;
            if (rsp_valid) begin
                rsp_lat   = c;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= '0;
        mem[0] <= 32'h1122_3344;
        mem[1] <= 32'hDEAD_BEEF;
        mem[2] <= 32'hCAFE_F00D;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready",      {31'b0, req_ready},    32'd1);
        checkOutput("rst_rsp_valid",      {31'b0, rsp_valid},    32'd0);
        checkOutput("rst_rsp_rdata",      rsp_rdata,             32'd0);
        checkOutput("rst_rsp_err",        {31'b0, rsp_err},      32'd0);
        checkOutput("rst_mem_read",       {31'b0, mem_read},     32'd0);
        checkOutput("rst_mem_write_en",   {31'b0, mem_write_en}, 32'd0);
        checkOutput("rst_mem_addr",       mem_addr,              32'd0);
        checkOutput("rst_mem_write_data", mem_write_data,        32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, F3_B, 32'h7, '0);
        checkOutput("lb_rdata", got_rdata, 32'hFFFF_FFDE);
        checkOutput("lb_lat",   32'(rsp_lat), 32'd2);
        checkOutput("lb_err",   {31'b0, got_err}, 32'd0);
        checkOutput("lb_raddr", rd_addr, 32'h4);

        applyStimulus(1'b0, F3_BU, 32'h7, '0);
        checkOutput("lbu_rdata", got_rdata, 32'h0000_00DE);
        checkOutput("lbu_lat",   32'(rsp_lat), 32'd2);

        applyStimulus(1'b0, F3_H, 32'h6, '0);
        checkOutput("lh_rdata", got_rdata, 32'hFFFF_DEAD);
        checkOutput("lh_lat",   32'(rsp_lat), 32'd2);

        applyStimulus(1'b0, F3_HU, 32'h4, '0);
        checkOutput("lhu_rdata", got_rdata, 32'h0000_BEEF);
        checkOutput("lhu_lat",   32'(rsp_lat), 32'd2);

        applyStimulus(1'b1, F3_B, 32'h5, 32'h0000_0012);
        checkOutput("sb_reads",  32'(n_reads),  32'd1);
        checkOutput("sb_writes", 32'(n_writes), 32'd1);
        checkOutput("sb_wdata",  wr_data, 32'hDEAD_12EF);
        checkOutput("sb_waddr",  wr_addr, 32'h4);
        checkOutput("sb_lat",    32'(rsp_lat), 32'd2);
        checkOutput("sb_rdata",  got_rdata, 32'd0);

        applyStimulus(1'b0, F3_W, 32'h4, '0);
        checkOutput("lw_after_sb", got_rdata, 32'hDEAD_12EF);

        applyStimulus(1'b1, F3_W, 32'h28, 32'h0000_0032);
        checkOutput("sw_lat",    32'(rsp_lat), 32'd1);
        checkOutput("sw_writes", 32'(n_writes), 32'd1);
        checkOutput("sw_reads",  32'(n_reads),  32'd0);
        checkOutput("sw_wdata",  wr_data, 32'h0000_0032);
        checkOutput("sw_waddr",  wr_addr, 32'h28);

        applyStimulus(1'b0, F3_W, 32'h28, '0);
        checkOutput("lw_after_sw", got_rdata, 32'h0000_0032);

        applyStimulus(1'b0, F3_W, 32'h2, '0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("lw_mis_err",   {31'b0, got_err}, 32'd1);
        checkOutput("lw_mis_lat",   32'(rsp_lat), 32'd1);
        checkOutput("lw_mis_rdata", got_rdata, 32'd0);
        checkOutput("lw_mis_strb",  32'(n_reads + n_writes), 32'd0);
`else
        checkOutput("lw_mis_err",   {31'b0, got_err}, 32'd0);
        checkOutput("lw_mis_lat",   32'(rsp_lat), 32'd2);
        checkOutput("lw_mis_rdata", got_rdata, 32'h1122_3344);
`endif

        applyStimulus(1'b0, F3_H, 32'h5, '0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("lh_mis_err",   {31'b0, got_err}, 32'd1);
        checkOutput("lh_mis_rdata", got_rdata, 32'd0);
`else
        checkOutput("lh_mis_err",   {31'b0, got_err}, 32'd0);
        checkOutput("lh_mis_rdata", got_rdata, 32'h0000_12EF);
`endif

        applyStimulus(1'b0, F3_W, 32'h1000, '0);
        checkOutput("oor_err",   {31'b0, got_err}, 32'd1);
        checkOutput("oor_lat",   32'(rsp_lat), 32'd1);
        checkOutput("oor_rdata", got_rdata, 32'd0);
        checkOutput("oor_strb",  32'(n_reads + n_writes), 32'd0);

        applyStimulus(1'b0, 3'b011, 32'h4, '0);
        checkOutput("f3_011_err",   {31'b0, got_err}, 32'd1);
        checkOutput("f3_011_lat",   32'(rsp_lat), 32'd1);
        checkOutput("f3_011_rdata", got_rdata, 32'd0);

        applyStimulus(1'b1, F3_BU, 32'h4, 32'h0000_00AA);
        checkOutput("sbu_err",    {31'b0, got_err}, 32'd1);
        checkOutput("sbu_writes", 32'(n_writes), 32'd0);

        applyStimulus(1'b0, F3_W, 32'hFFC, '0);
        checkOutput("lw_top_err",   {31'b0, got_err}, 32'd0);
        checkOutput("lw_top_rdata", got_rdata, 32'd0);

        // SH to 0x8, then reset while the merge write is on the bus.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_H;
        req_addr   = 32'h8;
        req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(negedge clk);
        checkOutput("sh_access_read", {31'b0, mem_read}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("sh_rmw_write_en", {31'b0, mem_write_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_write_en", {31'b0, mem_write_en}, 32'd0);
        checkOutput("rst_mid_wdata",    mem_write_data, 32'd0);
        checkOutput("rst_mid_rsp",      {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rel_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("sh_killed_mem", mem[2], 32'hCAFE_F00D);

        applyStimulus(1'b0, F3_W, 32'h8, '0);
        checkOutput("lw_after_kill", got_rdata, 32'hCAFE_F00D);

        checkOutput("no_rd_wr_overlap", {31'b0, overlap}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
